// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - radix-2 Booth sequential multiplier (IDLE/CALC/DONE FSM)
// Define BOOTH_SIGNED_EN for two's-complement operands; the default build multiplies unsigned.
module booth_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

`ifdef BOOTH_SIGNED_EN
  localparam int IW = WIDTH;
`else
  // Unsigned operands ride one extra zero bit so the signed Booth recoding stays exact.
  localparam int IW = WIDTH + 1;
`endif
  localparam int AW = IW + 1;
  localparam int N  = IW;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        m_q, m_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [IW-1:0]        q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [AW-1:0]        acc_sum;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    acc_sum   = acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef BOOTH_SIGNED_EN
          m_d = {op_a[WIDTH-1], op_a};
          q_d = op_b;
`else
          m_d = {2'b00, op_a};
          q_d = {1'b0, op_b};
`endif
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(N);
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        case ({q_q[0], qm1_q})
          2'b01:   acc_sum = acc_q + m_q;
          2'b10:   acc_sum = acc_q - m_q;
          default: acc_sum = acc_q;
        endcase
        // Add/subtract and the arithmetic shift of {ACC,Q,Q(-1)} share one edge.
        acc_d = {acc_sum[AW-1], acc_sum[AW-1:1]};
        q_d   = {acc_sum[0], q_q[IW-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        product_d = {acc_q[2*WIDTH-IW-1:0], q_q};
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - self-checking bench for booth_multiplier (follows BOOTH_SIGNED_EN)
module tb_booth_multiplier;
  localparam int W = 8;
`ifdef BOOTH_SIGNED_EN
  localparam int LAT = W + 1;
  localparam logic [2*W-1:0] E_FF  = 16'h0001;
  localparam logic [2*W-1:0] E_FB6 = 16'hFFE2;
  localparam logic [2*W-1:0] E_2M1 = 16'hFFFE;
`else
  localparam int LAT = W + 2;
  localparam logic [2*W-1:0] E_FF  = 16'hFE01;
  localparam logic [2*W-1:0] E_FB6 = 16'h05E2;
  localparam logic [2*W-1:0] E_2M1 = 16'h01FE;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int failures = 0;

  booth_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
`ifdef BOOTH_SIGNED_EN
    sa = $signed(a);
    sb = $signed(b);
`else
    sa = int'(a);
    sb = int'(b);
`endif
    return (2*W)'(sa * sb);
  endfunction

  // Reference: a start seen while idle yields done exactly LAT edges later with a*b.
  logic           m_busy = 1'b0;
  logic           m_done = 1'b0;
  logic [2*W-1:0] m_prod = '0;
  int             m_cnt = 0;
  logic [W-1:0]   a_cap = '0;
  logic [W-1:0]   b_cap = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == LAT - 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_prod <= ref_mul(a_cap, b_cap);
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        a_cap  <= op_a;
        b_cap  <= op_b;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("product", 32'(product), 32'(m_prod));
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    op_a  = W'($urandom);
    op_b  = W'($urandom);
  endtask

  task automatic wait_done(input string name, output int n, output logic [2*W-1:0] p);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done && n < 40);
    check({name, "_done_seen"}, 32'(done), 32'd1);
    p = product;
  endtask

  task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2*W-1:0] exp);
    int n;
    logic [2*W-1:0] p;
    issue(a, b);
    wait_done(name, n, p);
    check(name, 32'(p), 32'(exp));
    check({name, "_lat"}, 32'(n), 32'(LAT));
  endtask

  task automatic count_dones(input string name, input int cycles);
    int extra;
    extra = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) extra++;
    end
    check(name, 32'(extra), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [2*W-1:0] p;
    #3;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;

    run("mul_7x3", 8'd7, 8'd3, 16'h0015);
    run("mul_80x80", 8'h80, 8'h80, 16'h4000);
    run("mul_FBx06", 8'hFB, 8'h06, E_FB6);
    run("mul_FFxFF", 8'hFF, 8'hFF, E_FF);

    issue(8'd5, 8'd5);
    repeat (2) @(posedge clk);
    #2;
    op_a  = 8'd9;
    op_b  = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done("repulse", n, p);
    check("repulse_product", 32'(p), 32'h19);
    check("repulse_lat", 32'(n), 32'(LAT - 3));
    count_dones("repulse_extra_done", 30);

    issue(8'd3, 8'd3);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    count_dones("abort_no_done", 20);
    check("abort_product_held", 32'(product), 32'd0);
    run("mul_2xm1", 8'd2, 8'hFF, E_2M1);

    run("b2b_4x4", 8'd4, 8'd4, 16'h0010);
    run("b2b_6x7", 8'd6, 8'd7, 16'h002A);

    repeat (800) begin
      @(posedge clk);
      #2;
      start = ($urandom_range(0, 7) == 0);
      op_a  = W'($urandom);
      op_b  = W'($urandom);
    end
    start = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
